pcie_tx_pkt_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges two 256-bit AXI-Stream response sources onto the single PCIe TX stream of the RDM block design. Source 0 is the RDM response path; source 1 is the control/management reply path. A grant is held from the first beat to tlast, so packets never interleave. The block also keeps per-source packet counters and a stall watchdog for bring-up.

---
 rtl/pcie_tx_pkt_arbiter.sv | 80 ++++++++
 tb/tb_pcie_tx_pkt_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_pkt_arbiter.sv
// pcie_tx_pkt_arbiter: packet-level round-robin merge of two AXIS sources onto PCIe TX, with packet counters and a stall watchdog
module pcie_tx_pkt_arbiter #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32,
  parameter int USER_W = 64,
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic [KEEP_W-1:0] s0_tkeep,
  input  logic [USER_W-1:0] s0_tuser,
  input  logic              s0_tlast,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic [KEEP_W-1:0] s1_tkeep,
  input  logic [USER_W-1:0] s1_tuser,
  input  logic              s1_tlast,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              stall_err
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STALL_LIMIT);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state, state_nxt;
  logic last_owner, g0, g1, hs, eop;
  logic [SW-1:0] stall_ctr, stall_nxt;
  always_comb begin
    g0 = state == GRANT0;
    g1 = state == GRANT1;
    m_tdata = g0 ? s0_tdata : g1 ? s1_tdata : '0;
    m_tkeep = g0 ? s0_tkeep : g1 ? s1_tkeep : '0;
    m_tuser = g0 ? s0_tuser : g1 ? s1_tuser : '0;
    m_tlast = g0 ? s0_tlast : g1 & s1_tlast;
    m_tvalid = g0 ? s0_tvalid : g1 & s1_tvalid;
    s0_tready = g0 & m_tready;
    s1_tready = g1 & m_tready;
    grant = {g1, g0};
    hs = m_tvalid & m_tready;
    eop = hs & m_tlast;
    state_nxt = state;
    // on contention the source that did not own the previous packet wins
    if (state == IDLE)
      state_nxt = (s0_tvalid && (!s1_tvalid || last_owner)) ? GRANT0 : s1_tvalid ? GRANT1 : IDLE;
    else if (eop)
      state_nxt = IDLE;
    stall_nxt = (state == IDLE || hs) ? '0 : (stall_ctr == LIM) ? stall_ctr : stall_ctr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= IDLE;
      last_owner <= 1'b1;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      stall_ctr <= '0;
      stall_err <= 1'b0;
    end else begin
      state <= state_nxt;
      stall_ctr <= stall_nxt;
      stall_err <= stall_err | (stall_nxt == LIM);
      if (eop) begin
        last_owner <= g1;
        pkt_cnt0 <= pkt_cnt0 + CNT_W'(g0);
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(g1);
      end
    end
  end
endmodule

// File: tb/tb_pcie_tx_pkt_arbiter.sv
// tb_pcie_tx_pkt_arbiter: directed bench for the two-source packet arbiter
module tb_pcie_tx_pkt_arbiter;
  logic clk = 0, sys_rst = 1;
  logic [255:0] s0_tdata = '0, s1_tdata = '0, m_tdata;
  logic [31:0] s0_tkeep = '1, s1_tkeep = '1, m_tkeep;
  logic [63:0] s0_tuser = 64'h5a5a, s1_tuser = 64'ha5a5, m_tuser;
  logic s0_tlast = 0, s1_tlast = 0, s0_tvalid = 0, s1_tvalid = 0, s0_tready, s1_tready;
  logic m_tlast, m_tvalid, m_tready = 0;
  logic [1:0] grant;
  logic [31:0] pkt_cnt0, pkt_cnt1;
  logic stall_err;
  int checks = 0, errors = 0;
  pcie_tx_pkt_arbiter #(.STALL_LIMIT(16)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .grant(grant),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .stall_err(stall_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic src0(input logic v, input logic [15:0] d, input logic l);
    s0_tvalid = v;
    s0_tdata = 256'(d);
    s0_tlast = l;
  endtask
  task automatic src1(input logic v, input logic [15:0] d, input logic l);
    s1_tvalid = v;
    s1_tdata = 256'(d);
    s1_tlast = l;
  endtask
  initial begin
    int got;
    logic [1:0] eg;
    step(); step();
    m_tready = 1;
    #1;
    chk("rst_grant", 64'(grant), 0);
    chk("rst_mvalid", 64'(m_tvalid), 0);
    chk("rst_mlast", 64'(m_tlast), 0);
    chk("rst_s0ready", 64'(s0_tready), 0);
    chk("rst_mdata", m_tdata[63:0], 0);
    chk("rst_cnt0", 64'(pkt_cnt0), 0);
    chk("rst_stall", 64'(stall_err), 0);
    // single source, 4 beats
    sys_rst = 0;
    step(); src0(1, 1, 0); #1;
    chk("t1_idle_grant", 64'(grant), 0);
    chk("t1_idle_s0ready", 64'(s0_tready), 0);
    for (int b = 0; b < 4; b++) begin
      step(); src0(1, 16'(b + 1), b == 3); #1;
      chk("t1_grant", 64'(grant), 1);
      chk("t1_data", m_tdata[63:0], 64'(b + 1));
      chk("t1_last", 64'(m_tlast), 64'(b == 3));
      chk("t1_s0ready", 64'(s0_tready), 1);
    end
    chk("t1_user", m_tuser, 64'h5a5a);
    step(); src0(0, 0, 0); #1;
    chk("t1_back_idle", 64'(grant), 0);
    chk("t1_cnt0", 64'(pkt_cnt0), 1);
    // both sources continuously valid, alternating 2-beat packets
    sys_rst = 1; step(); sys_rst = 0;
    src0(1, 16'ha0, 0); src1(1, 16'hb0, 0); #1;
    for (int p = 0; p < 6; p++) begin
      chk("t2_gap_grant", 64'(grant), 0);
      chk("t2_gap_valid", 64'(m_tvalid), 0);
      for (int b = 0; b < 2; b++) begin
        step();
        src0(1, 16'(16'ha0 + p * 2 + b), b == 1);
        src1(1, 16'(16'hb0 + p * 2 + b), b == 1);
        #1;
        eg = (p % 2 == 0) ? 2'b01 : 2'b10;
        chk("t2_grant", 64'(grant), 64'(eg));
        chk("t2_data", m_tdata[63:0], 64'(((p % 2 == 0) ? 16'ha0 : 16'hb0) + p * 2 + b));
        chk("t2_last", 64'(m_tlast), 64'(b == 1));
      end
      step(); src0(1, 16'(16'ha0 + p * 2 + 2), 0); src1(1, 16'(16'hb0 + p * 2 + 2), 0); #1;
    end
    chk("t2_cnt0", 64'(pkt_cnt0), 3);
    chk("t2_cnt1", 64'(pkt_cnt1), 3);
    // s1 requests while s0 is mid-packet
    src0(0, 0, 0); src1(0, 0, 0);
    step(); src0(1, 16'hc0, 0); #1;
    chk("t3_idle", 64'(grant), 0);
    for (int b = 0; b < 5; b++) begin
      step(); src0(1, 16'(16'hc0 + b), b == 4);
      if (b == 1) src1(1, 16'hd0, 1);
      #1;
      chk("t3_grant", 64'(grant), 1);
      chk("t3_data", m_tdata[63:0], 64'(16'hc0 + b));
      chk("t3_s1ready", 64'(s1_tready), 0);
    end
    step(); src0(0, 0, 0); #1;
    chk("t3_gap", 64'(grant), 0);
    chk("t3_gap_s1ready", 64'(s1_tready), 0);
    step(); #1;
    chk("t3_s1_grant", 64'(grant), 2);
    chk("t3_s1_data", m_tdata[63:0], 64'hd0);
    chk("t3_s1_user", m_tuser, 64'ha5a5);
    chk("t3_s1ready", 64'(s1_tready), 1);
    step(); src1(0, 0, 0); #1;
    chk("t3_single_done", 64'(grant), 0);
    chk("t3_cnt0", 64'(pkt_cnt0), 4);
    chk("t3_cnt1", 64'(pkt_cnt1), 4);
    // backpressure pattern 1,0,0 repeating over 8 beats
    step(); src0(1, 16'he0, 0); #1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      step();
      m_tready = (c % 3 == 0);
      src0(1, 16'(16'he0 + got), got == 7);
      #1;
      chk("t4_grant", 64'(grant), 1);
      chk("t4_mirror", 64'(s0_tready), 64'(m_tready));
      chk("t4_data", m_tdata[63:0], 64'(16'he0 + got));
      if (m_tready) got++;
    end
    chk("t4_beats", 64'(got), 8);
    step(); src0(0, 0, 0); m_tready = 1; #1;
    chk("t4_idle", 64'(grant), 0);
    chk("t4_cnt0", 64'(pkt_cnt0), 5);
    // watchdog: s1 granted, no handshake for 16 cycles
    m_tready = 0; src1(1, 16'hf0, 0);
    for (int g = 1; g <= 16; g++) begin
      step(); #1;
      chk("t5_grant", 64'(grant), 2);
      chk("t5_stall_pre", 64'(stall_err), 0);
    end
    step(); #1;
    chk("t5_stall_set", 64'(stall_err), 1);
    m_tready = 1; #1;
    chk("t5_data", m_tdata[63:0], 64'hf0);
    step(); src1(1, 16'hf1, 1); #1;
    chk("t5_last", 64'(m_tlast), 1);
    step(); src1(0, 0, 0); #1;
    chk("t5_idle", 64'(grant), 0);
    chk("t5_cnt1", 64'(pkt_cnt1), 5);
    chk("t5_sticky", 64'(stall_err), 1);
    sys_rst = 1; step(); sys_rst = 0; #1;
    chk("t5_clr", 64'(stall_err), 0);
    chk("t5_clr_cnt1", 64'(pkt_cnt1), 0);
    // reset during beat 3 of a 6-beat s0 packet
    src0(1, 16'h10, 0);
    for (int b = 0; b < 3; b++) begin
      step(); src0(1, 16'(16'h10 + b), 0); #1;
      chk("t6_grant", 64'(grant), 1);
    end
    sys_rst = 1;
    step(); src0(1, 16'h13, 0); src1(1, 16'h20, 1); #1;
    chk("t6_rst_grant", 64'(grant), 0);
    chk("t6_rst_s0ready", 64'(s0_tready), 0);
    chk("t6_rst_cnt0", 64'(pkt_cnt0), 0);
    sys_rst = 0;
    for (int b = 3; b < 6; b++) begin
      step(); src0(1, 16'(16'h10 + b), b == 5); #1;
      chk("t6_s0_first", 64'(grant), 1);
      chk("t6_data", m_tdata[63:0], 64'(16'h10 + b));
    end
    step(); src0(0, 0, 0); #1;
    chk("t6_cnt0", 64'(pkt_cnt0), 1);
    step(); #1;
    chk("t6_s1_next", 64'(grant), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
